// File: rtl/cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states,
// the running relation between the two operands, and the mapping from
// a relation to the one-hot result flags.
package cmp_pkg;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} cmp_state_t;

    typedef enum logic [1:0] {REL_EQ, REL_GT, REL_LT} cmp_rel_t;

    // Returns {agtb, aeqb, altb}; the unused encoding reads as equal so the
    // flags stay one-hot whatever the relation register holds.
    function automatic logic [2:0] rel_to_flags(input cmp_rel_t rel);
        case (rel)
            REL_GT:  return 3'b100;
            REL_LT:  return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

endpackage

// File: rtl/bit_cmp_cell.sv
// Next-relation function for one accepted bit pair. MSB-first streams
// freeze on the first difference; LSB-first streams let every later
// difference overwrite, so the most significant differing bit wins.
module bit_cmp_cell
    import cmp_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  cmp_rel_t cur_rel,
    input  logic     a_bit,
    input  logic     b_bit,
    output cmp_rel_t nxt_rel
);

    // Update the relation only when the bits differ and the stream order allows it
    always_comb begin
        nxt_rel = cur_rel;
        if ((a_bit ^ b_bit) && ((MSB_FIRST == 0) || (cur_rel == REL_EQ))) begin
            nxt_rel = a_bit ? REL_GT : REL_LT;
        end
    end

endmodule

// File: rtl/serial_mag_cmp.sv
// Bit-serial unsigned magnitude comparator. Operands stream in one bit
// pair per valid beat; after W beats a one-cycle done pulse marks the
// freshly registered agtb/aeqb/altb, which then hold until the final
// beat of the next comparison.
module serial_mag_cmp
    import cmp_pkg::*;
#(
    parameter int W         = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic agtb,
    output logic aeqb,
    output logic altb
);

    localparam int            CW       = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    cmp_state_t    state;
    cmp_state_t    state_nxt;
    cmp_rel_t      rel;
    cmp_rel_t      rel_nxt;
    logic [CW-1:0] cnt;
    logic          launch;
    logic          beat;
    logic          last_beat;

    bit_cmp_cell #(
        .MSB_FIRST(MSB_FIRST)
    ) u_cell (
        .cur_rel(rel),
        .a_bit  (a_bit),
        .b_bit  (b_bit),
        .nxt_rel(rel_nxt)
    );

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

    // Next-state decode plus the launch/beat strobes that steer the datapath
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        beat      = 1'b0;
        last_beat = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_valid) begin
                    beat = 1'b1;
                    if (cnt == LAST_CNT) begin
                        last_beat = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = S_SHIFT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Beat counter and running relation; a launch always starts from equal
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            rel <= REL_EQ;
        end else if (launch) begin
            cnt <= '0;
            rel <= REL_EQ;
        end else if (beat) begin
            rel <= rel_nxt;
            cnt <= last_beat ? '0 : cnt + CW'(1);
        end
    end

    // Result flags capture the final relation on the last beat and otherwise hold
    always_ff @(posedge clk) begin
        if (reset) begin
            {agtb, aeqb, altb} <= 3'b000;
        end else if (last_beat) begin
            {agtb, aeqb, altb} <= rel_to_flags(rel_nxt);
        end
    end

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Bench for serial_mag_cmp: two W=8 instances (MSB-first and LSB-first)
// are fed the same operands in their own bit order and must agree with a
// plain arithmetic compare; a W=1 instance covers the single-beat case.
module tb_serial_mag_cmp;

    logic clk = 1'b0;
    logic reset;

    logic start, bit_valid, ma_bit, mb_bit, la_bit, lb_bit;
    logic m_busy, m_done, m_agtb, m_aeqb, m_altb;
    logic l_busy, l_done, l_agtb, l_aeqb, l_altb;

    logic s_start, s_valid, s_a, s_b;
    logic s_busy, s_done, s_agtb, s_aeqb, s_altb;

    int       tests_run    = 0;
    int       tests_failed = 0;
    logic [2:0] hold;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         stall_after;
        int         stall_len;
        bit         chain_next;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    serial_mag_cmp #(.W(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
        .a_bit(ma_bit), .b_bit(mb_bit), .busy(m_busy), .done(m_done),
        .agtb(m_agtb), .aeqb(m_aeqb), .altb(m_altb)
    );

    serial_mag_cmp #(.W(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
        .a_bit(la_bit), .b_bit(lb_bit), .busy(l_busy), .done(l_done),
        .agtb(l_agtb), .aeqb(l_aeqb), .altb(l_altb)
    );

    serial_mag_cmp #(.W(1), .MSB_FIRST(1)) u_w1 (
        .clk(clk), .reset(reset), .start(s_start), .bit_valid(s_valid),
        .a_bit(s_a), .b_bit(s_b), .busy(s_busy), .done(s_done),
        .agtb(s_agtb), .aeqb(s_aeqb), .altb(s_altb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic checkPair(input string tag, input logic exp_busy, input logic exp_done, input logic [2:0] exp_flags);
        checkOutput({tag, " msb busy"}, 32'(m_busy), 32'(exp_busy));
        checkOutput({tag, " msb done"}, 32'(m_done), 32'(exp_done));
        checkOutput({tag, " msb flags"}, 32'({m_agtb, m_aeqb, m_altb}), 32'(exp_flags));
        checkOutput({tag, " lsb busy"}, 32'(l_busy), 32'(exp_busy));
        checkOutput({tag, " lsb done"}, 32'(l_done), 32'(exp_done));
        checkOutput({tag, " lsb flags"}, 32'({l_agtb, l_aeqb, l_altb}), 32'(exp_flags));
    endtask

    task automatic checkW1(input string tag, input logic exp_busy, input logic exp_done, input logic [2:0] exp_flags);
        checkOutput({tag, " busy"}, 32'(s_busy), 32'(exp_busy));
        checkOutput({tag, " done"}, 32'(s_done), 32'(exp_done));
        checkOutput({tag, " flags"}, 32'({s_agtb, s_aeqb, s_altb}), 32'(exp_flags));
    endtask

    // Reference result straight from unsigned arithmetic
    function automatic logic [2:0] model(input logic [7:0] a, input logic [7:0] b);
        if (a > b) return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    // One full comparison on both W=8 instances; start is scrambled during
    // SHIFT, and bit_valid/garbage bits accompany the launching start.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input int stall_after, input int stall_len,
                                 input logic [2:0] exp, input bit via_chain,
                                 input bit chain_next, input string name);
        if (!via_chain) begin
            start     = 1'b1;
            bit_valid = 1'b1;
            ma_bit = 1'b1; mb_bit = 1'b0; la_bit = 1'b1; lb_bit = 1'b0;
        end
        tick();
        start = 1'b0;
        checkPair({name, " enter"}, 1'b1, 1'b0, hold);
        for (int i = 0; i < 8; i++) begin
            bit_valid = 1'b1;
            ma_bit = a[7-i]; mb_bit = b[7-i];
            la_bit = a[i];   lb_bit = b[i];
            start  = 1'($urandom_range(0, 1));
            tick();
            if (i == 7) begin
                checkPair({name, " final"}, 1'b0, 1'b1, exp);
            end else begin
                checkPair({name, " beat"}, 1'b1, 1'b0, hold);
                if (i + 1 == stall_after) begin
                    for (int s = 0; s < stall_len; s++) begin
                        bit_valid = 1'b0;
                        ma_bit = 1'($urandom_range(0, 1)); mb_bit = 1'($urandom_range(0, 1));
                        la_bit = 1'($urandom_range(0, 1)); lb_bit = 1'($urandom_range(0, 1));
                        start  = 1'($urandom_range(0, 1));
                        tick();
                        checkPair({name, " stall"}, 1'b1, 1'b0, hold);
                    end
                end
            end
        end
        hold      = exp;
        bit_valid = 1'b0;
        if (chain_next) begin
            start = 1'b1;
        end else begin
            start = 1'b0;
            tick();
            checkPair({name, " idle"}, 1'b0, 1'b0, exp);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit via_chain;
        logic [7:0] ra, rb;
        bit chain;

        vecs[0] = '{8'hA5, 8'h5A, 0, 0, 1'b0, 3'b100};
        vecs[1] = '{8'h3C, 8'h3D, 0, 0, 1'b0, 3'b001};
        vecs[2] = '{8'h80, 8'h7F, 0, 0, 1'b0, 3'b100};
        vecs[3] = '{8'hFF, 8'hFF, 4, 3, 1'b1, 3'b010};
        vecs[4] = '{8'h01, 8'h02, 0, 0, 1'b0, 3'b001};
        vecs[5] = '{8'h00, 8'h00, 2, 1, 1'b0, 3'b010};
        vecs[6] = '{8'h00, 8'hFF, 7, 2, 1'b0, 3'b001};
        vecs[7] = '{8'hFE, 8'h7F, 0, 0, 1'b0, 3'b100};

        reset = 1'b1;
        start = 1'b0; bit_valid = 1'b0;
        ma_bit = 1'b0; mb_bit = 1'b0; la_bit = 1'b0; lb_bit = 1'b0;
        s_start = 1'b0; s_valid = 1'b0; s_a = 1'b0; s_b = 1'b0;
        hold = 3'b000;
        tick();
        tick();
        checkPair("reset", 1'b0, 1'b0, 3'b000);
        checkW1("w1 reset", 1'b0, 1'b0, 3'b000);
        reset = 1'b0;
        tick();
        checkPair("post reset", 1'b0, 1'b0, 3'b000);

        // W=1: start held through SHIFT, single beat completes, held start relaunches from DONE
        s_start = 1'b1;
        tick();
        checkW1("w1 enter", 1'b1, 1'b0, 3'b000);
        tick();
        checkW1("w1 wait", 1'b1, 1'b0, 3'b000);
        s_valid = 1'b1; s_a = 1'b1; s_b = 1'b0;
        tick();
        checkW1("w1 gt", 1'b0, 1'b1, 3'b100);
        s_valid = 1'b0;
        tick();
        checkW1("w1 relaunch", 1'b1, 1'b0, 3'b100);
        s_start = 1'b0;
        s_valid = 1'b1; s_a = 1'b0; s_b = 1'b1;
        tick();
        checkW1("w1 lt", 1'b0, 1'b1, 3'b001);
        s_valid = 1'b0;
        tick();
        checkW1("w1 idle", 1'b0, 1'b0, 3'b001);

        // Directed table
        via_chain = 1'b0;
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].a, vecs[v].b, vecs[v].stall_after, vecs[v].stall_len,
                          vecs[v].exp, via_chain, vecs[v].chain_next, $sformatf("vec%0d", v));
            via_chain = vecs[v].chain_next;
        end

        // Reset on the fifth beat aborts without a done pulse
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            ma_bit = 1'b1; mb_bit = 1'b0; la_bit = 1'b1; lb_bit = 1'b0;
            tick();
        end
        reset = 1'b1;
        tick();
        checkPair("rst abort", 1'b0, 1'b0, 3'b000);
        reset = 1'b0;
        bit_valid = 1'b0;
        tick();
        checkPair("rst no done", 1'b0, 1'b0, 3'b000);
        hold = 3'b000;
        applyStimulus(8'h10, 8'h0F, 0, 0, 3'b100, 1'b0, 1'b0, "after rst");

        // Random operands against the arithmetic model
        via_chain = 1'b0;
        for (int r = 0; r < 40; r++) begin
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom_range(0, 255));
            chain = (r != 39) && ($urandom_range(0, 2) == 0);
            applyStimulus(ra, rb, int'($urandom_range(0, 7)), int'($urandom_range(1, 3)),
                          model(ra, rb), via_chain, chain, $sformatf("rand%0d a=%0h b=%0h", r, ra, rb));
            via_chain = chain;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_mag_cmp.md
Name: serial_mag_cmp

Overview:
- Bit-serial magnitude comparator: two W-bit unsigned operands arrive one bit per accepted beat; after the last beat it reports a>b, a==b and a<b.
- Sequential counterpart of the 2-bit SOP greater-than comparator: same result semantics, but the operands are streamed rather than presented in parallel.
- Sits behind serial front-ends, such as switch or shift-register capture logic, that deliver operands bit by bit.

Parameters:
- W, 8, operand width in bits (legal range 1..32).
- MSB_FIRST, 1, bit order: 1 means MSB arrives first, 0 means LSB arrives first.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a new comparison; sampled in IDLE or DONE only.
- bit_valid  in  1  a_bit/b_bit carry a valid operand bit this cycle.
- a_bit  in  1  current bit of operand a.
- b_bit  in  1  current bit of operand b.
- busy  out  1  high while in SHIFT (a comparison is collecting bits).
- done  out  1  one-cycle pulse: results just became valid.
- agtb  out  1  result a > b.
- aeqb  out  1  result a == b.
- altb  out  1  result a < b.

Behaviour:
- Reset, synchronous, takes priority over all inputs:
  - state goes to IDLE, cnt to 0, the internal relation register to EQ.
  - busy=0, done=0, agtb=0, aeqb=0, altb=0.
  - Outputs stay 0 until the first completed comparison.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 moves to SHIFT, clears cnt to 0 and sets the relation register to EQ.
  - Result outputs keep their previous values.
  - bit_valid is ignored.
- SHIFT (busy=1):
  - Each cycle with bit_valid=1 consumes one bit pair and increments cnt.
  - bit_valid=0 stalls with no change; there is no timeout.
  - start is ignored.
- Relation update per accepted beat, with d = a_bit XOR b_bit:
  - MSB_FIRST=1: if the relation is EQ and d=1, set GT when a_bit=1, else LT. Once GT or LT, the relation is frozen.
  - MSB_FIRST=0: if d=1, overwrite the relation with GT when a_bit=1, else LT. If d=0, the relation is unchanged, so the most significant differing bit wins.
- Termination: the beat accepted with cnt==W-1 completes the operand.
  - Next state is DONE.
  - agtb/aeqb/altb are registered from the final relation on that same edge.
- DONE (one cycle):
  - done=1, busy=0.
  - Results are exactly one-hot (agtb+aeqb+altb == 1).
  - start=1 goes directly to SHIFT (back-to-back operation); otherwise go to IDLE.
- Latency: done is asserted in the cycle after the final valid beat.
- Result hold: agtb/aeqb/altb hold from DONE until the final beat of the next comparison. They do not change on start or during SHIFT.
- Counter: cnt is $clog2(W+1) bits wide and never exceeds W-1 in SHIFT. With W=1, a single beat completes the comparison.
- Reset mid-SHIFT aborts the comparison: results return to 0 and no done pulse is produced.
- start and bit_valid together in IDLE: only start acts; that beat's bits are not consumed.

Decomposition:
- Package cmp_pkg:
  - typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} cmp_state_t.
  - typedef enum logic [1:0] {REL_EQ, REL_GT, REL_LT} cmp_rel_t.
  - function rel_to_flags() mapping cmp_rel_t to {agtb, aeqb, altb}.
- Sub-module bit_cmp_cell: purely combinational next-relation function.
  - Inputs: cur_rel, a_bit, b_bit.
  - Output: nxt_rel.
  - Parameter MSB_FIRST.
  - Reusable and unit-testable in isolation.
- serial_mag_cmp holds the FSM, counter and output registers.

Test Plan:
- W=8, MSB_FIRST=1: stream a=0xA5, b=0x5A, one beat per cycle -> done high in the cycle after beat 8; agtb=1, aeqb=0, altb=0.
- W=8, MSB_FIRST=0: stream a=0x3C, b=0x3D, LSB first -> altb=1. Repeat with a=0x80, b=0x7F -> agtb=1, confirming the MSB difference overrides the earlier LSB differences.
- W=8, a=b=0xFF, with bit_valid dropped for 3 cycles after beat 4 -> busy held through the stall; done exactly 1 cycle after beat 8; aeqb=1.
- Back-to-back: start asserted during DONE, then a=0x01, b=0x02 -> no IDLE cycle; previous results held until the final beat; new result altb=1.
- Assert reset at beat 5 of a comparison -> next cycle busy=0, all results 0, no done pulse. A following start plus 8 beats of a=0x10, b=0x0F -> agtb=1.
- W=1: start, then a single beat a=1, b=0 -> done the next cycle with agtb=1. start held during SHIFT has no effect.
